// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream FIFO and sends them as 8N1 (optional even parity) UART frames.
// Ports:
//   CLOCK      rising-edge system clock
//   RESET      asynchronous active-high reset
//   ENABLE     1 = allowed to start new frames
//   F_EMPTY_N  upstream FIFO has at least one byte
//   FIFO_DATA  upstream read data, valid the cycle after READ
//   READ       one-cycle read strobe to the FIFO
//   TX         serial line, idles high
//   BUSY       high while a byte is fetched or transmitted
//   BYTE_COUNT frames completed since reset, wraps silently
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        F_EMPTY_N,
  input  logic [7:0]  FIFO_DATA,
  output logic        READ,
  output logic        TX,
  output logic        BUSY,
  output logic [15:0] BYTE_COUNT
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [W-1:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, last, go, tx_n, on_line;
  logic [15:0] cnt_n;
  assign last = baud == LAST;
  assign go = ENABLE && F_EMPTY_N;
  assign on_line = state == START || state == DATA || state == PARITY || state == STOP;
  always_comb begin
    state_n = state;
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    cnt_n = BYTE_COUNT;
    baud_n = on_line && !last ? baud + 1'b1 : '0;
    case (state)
      IDLE: state_n = go ? FETCH : IDLE;
      FETCH: state_n = LOAD;
      LOAD: begin
        sh_n = FIFO_DATA;
        par_n = ^FIFO_DATA;
        idx_n = '0;
        state_n = START;
      end
      START: state_n = last ? DATA : START;
      DATA: if (last) begin
        sh_n = sh >> 1;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: state_n = last ? STOP : PARITY;
      STOP: if (last) begin
        cnt_n = BYTE_COUNT + 16'd1;
        state_n = go ? FETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are decoded from the next state so they leave the flops aligned with the state register.
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      BYTE_COUNT <= '0;
      TX <= 1'b1;
      READ <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      BYTE_COUNT <= cnt_n;
      TX <= tx_n;
      READ <= state_n == FETCH;
      BUSY <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed table-driven bench for fifo_uart_tx with a small FIFO model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic fe;
  logic [7:0] rdata;
  logic rd, tx, busy;
  logic [15:0] cnt;
  logic fe1 = 1'b0, en1 = 1'b0;
  logic [7:0] fd1 = 8'h00;
  logic rd1, tx1, busy1;
  logic [15:0] cnt1;
  logic [7:0] mem [16];
  int wp = 0, rp = 0;
  int rd_pulses = 0, b2b_reads = 0;
  logic rd_prev = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .F_EMPTY_N(fe), .FIFO_DATA(rdata),
    .READ(rd), .TX(tx), .BUSY(busy), .BYTE_COUNT(cnt));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .CLOCK(clk), .RESET(rst), .ENABLE(en1), .F_EMPTY_N(fe1), .FIFO_DATA(fd1),
    .READ(rd1), .TX(tx1), .BUSY(busy1), .BYTE_COUNT(cnt1));

  assign fe = wp != rp;

  always @(posedge clk) if (rd) begin
    rdata <= mem[rp[3:0]];
    rp <= rp + 1;
  end

  always @(negedge clk) begin
    if (rd) rd_pulses++;
    if (rd && rd_prev) b2b_reads++;
    rd_prev <= rd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [10:0] seq, input int n);
    logic [63:0] r = '0;
    for (int i = n - 1; i >= 0; i--)
      for (int k = 0; k < CPB; k++) r = {r[62:0], seq[i]};
    return r;
  endfunction

  task automatic push(input logic [7:0] d);
    mem[wp[3:0]] = d;
    wp++;
  endtask

  // Called on a negedge; waits for READ, then samples every cycle through the stop (or parity+stop) bit.
  task automatic run_frame(input string nm, input bit sel, input int nbits, input int drop_at,
                           output int waited, output logic [63:0] cap, output logic ok);
    waited = 0;
    cap = '0;
    while (!(sel ? rd1 : rd) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = sel ? rd1 : rd;
    chk({nm, "_read"}, ok, 1);
    if (!ok) return;
    if (sel) fe1 = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_load"}, sel ? busy1 : busy, 1);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      cap = {cap[62:0], sel ? tx1 : tx};
      if (i == drop_at) en = 1'b0;
    end
  endtask

  task automatic frame_check(input string nm, input bit sel, input int nbits, input logic [10:0] seq,
                             input int exp_wait, input int drop_at, input logic [15:0] cnt_before);
    int waited;
    logic [63:0] cap;
    logic ok;
    logic [15:0] nxt;
    nxt = cnt_before + 16'd1;
    run_frame(nm, sel, nbits, drop_at, waited, cap, ok);
    if (!ok) return;
    chk({nm, "_wait"}, 64'(waited), 64'(exp_wait));
    chk({nm, "_tx"}, cap, expand(seq, nbits));
    chk({nm, "_cnt_stop"}, sel ? cnt1 : cnt, cnt_before);
    @(negedge clk);
    chk({nm, "_cnt_done"}, sel ? cnt1 : cnt, nxt);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] seq;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [15:0] exp_cnt;
    int p0, n;
    tbl[0] = '{8'hA5, 11'b0_0_10100101_1};
    tbl[1] = '{8'h01, 11'b0_0_10000000_1};
    tbl[2] = '{8'h80, 11'b0_0_00000001_1};
    tbl[3] = '{8'hFF, 11'b0_0_11111111_1};
    tbl[4] = '{8'h00, 11'b0_0_00000000_1};
    tbl[5] = '{8'h3C, 11'b0_0_00111100_1};
    exp_cnt = 16'd0;

    #1 rst = 1'b1;
    en = 1'b1;
    push(8'h11);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_read", rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk);
    chk("rst_held_no_read", rd, 0);
    wp = rp;
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      push(tbl[i].data);
      frame_check($sformatf("vec%0d", i), 1'b0, 10, tbl[i].seq, 1, -1, exp_cnt);
      exp_cnt++;
    end

    p0 = rd_pulses;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    frame_check("b2b1", 1'b0, 10, 11'b0_0_10000000_1, 1, -1, exp_cnt);
    exp_cnt++;
    frame_check("b2b2", 1'b0, 10, 11'b0_0_01000000_1, 0, -1, exp_cnt);
    exp_cnt++;
    frame_check("b2b3", 1'b0, 10, 11'b0_0_11000000_1, 0, -1, exp_cnt);
    exp_cnt++;
    chk("b2b_cnt", cnt, 16'd9);
    repeat (3) @(negedge clk);
    chk("b2b_reads", 64'(rd_pulses - p0), 3);
    chk("b2b_idle_busy", busy, 0);

    en1 = 1'b1;
    fd1 = 8'h07;
    fe1 = 1'b1;
    frame_check("par07", 1'b1, 11, 11'b0_11100000_1_1, 1, -1, 16'd0);
    fd1 = 8'h03;
    fe1 = 1'b1;
    frame_check("par03", 1'b1, 11, 11'b0_11000000_0_1, 1, -1, 16'd1);

    push(8'h55);
    push(8'h66);
    frame_check("en_drop", 1'b0, 10, 11'b0_0_10101010_1, 1, 18, exp_cnt);
    exp_cnt++;
    p0 = rd_pulses;
    repeat (20) @(negedge clk);
    chk("en_drop_no_read", 64'(rd_pulses - p0), 0);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_tx", tx, 1);

    wp = rp;
    push(8'h00);
    push(8'hAA);
    en = 1'b1;
    n = 0;
    while (!rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_read", rd, 1);
    repeat (27) @(negedge clk);
    chk("mid_bit5_tx", tx, 0);
    chk("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_tx", tx, 1);
    chk("async_busy", busy, 0);
    chk("async_cnt", cnt, 0);
    chk("async_read", rd, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_edge_read", rd, 1);
    exp_cnt = 16'd0;
    frame_check("after_rst", 1'b0, 10, 11'b0_0_01010101_1, 0, -1, exp_cnt);
    exp_cnt++;

    @(negedge clk);
    force dut.BYTE_COUNT = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.BYTE_COUNT;
    @(negedge clk);
    chk("preload_cnt", cnt, 16'hFFFF);
    push(8'h3C);
    frame_check("wrap", 1'b0, 10, 11'b0_0_00111100_1, 1, -1, 16'hFFFF);

    chk("no_b2b_read", 64'(b2b_reads), 0);
    chk("read_total", 64'(rd_pulses), 13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
